seq_multiplier: RTL and testbench

Parametrised, iterative shift-add integer multiplier with a valid/ready handshake and selectable signed or unsigned operation. It replaces the fixed 8x8 combinational array multiplier wherever area matters more than latency. It accepts one operand pair, computes one multiplier bit per clock and holds the 2*WIDTH-bit product until the consumer takes it.

---
 rtl/seq_multiplier_if.sv | 27 ++
 rtl/seq_multiplier.sv | 118 +++++++++++
 tb/tb_seq_multiplier.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier.
//   master: producer/consumer side (drives operands, abort, out_ready)
//   slave : multiplier side (drives in_ready, out_valid, z, busy)
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 abort;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   z;
  logic                 busy;

  modport master (
    output in_valid, is_signed, a, b, abort, out_ready,
    input  in_ready, out_valid, z, busy
  );

  modport slave (
    input  in_valid, is_signed, a, b, abort, out_ready,
    output in_ready, out_valid, z, busy
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : in_valid/in_ready/is_signed/a/b operand handshake,
//                abort cancel, out_valid/out_ready/z result handshake, busy
// Signed operation multiplies magnitudes and negates the product at the end.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_multiplier_if.slave bus
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mult_q, mult_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    z_q, z_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_sum;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which fits unsigned.
  assign a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? ((~bus.a) + WIDTH'(1)) : bus.a;
  assign b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? ((~bus.b) + WIDTH'(1)) : bus.b;

  // Accumulator plus the current partial product.
  assign acc_sum = acc_q + (mult_q[0] ? (PW'(mcand_q) << cnt_q) : '0);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mult_q      <= '0;
      acc_q       <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mult_q      <= mult_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mult_d      = mult_q;
    acc_d       = acc_q;
    z_d         = z_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        // abort on the accept edge suppresses the accept
        if (bus.in_valid && !bus.abort) begin
          mcand_d = a_mag;
          mult_d  = b_mag;
          neg_d   = bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.abort) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          acc_d  = acc_sum;
          mult_d = mult_q >> 1;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            z_d         = neg_q ? ((~acc_sum) + PW'(1)) : acc_sum;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (bus.abort || bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench: directed WIDTH=8 cases and a randomized WIDTH=16 sweep.
module tb_seq_multiplier;
  localparam int unsigned W8  = 8;
  localparam int unsigned W16 = 16;
  localparam int unsigned N_RAND = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(W8))  if8 ();
  seq_multiplier_if #(.WIDTH(W16)) if16 ();

  seq_multiplier #(.WIDTH(W8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  seq_multiplier #(.WIDTH(W16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  longint cyc = 0;
  bit rand_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] z;
    longint      edge_no;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  logic ov8_q = 1'b0;
  logic ov16_q = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer product truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(int unsigned w, bit sgn, logic [31:0] a, logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] mask;
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  // Monitor for the WIDTH=8 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
    end else begin
      if (if8.out_valid && !ov8_q) begin
        if (q8.size() == 0) check("w8_spurious_out_valid", 64'(q8.size()), 64'd1);
        else check("w8_latency", 64'(cyc - q8[0].edge_no), 64'(W8));
      end
      if (if8.out_valid && if8.out_ready && !if8.abort && q8.size() > 0) begin
        check("w8_z", 64'(if8.z), q8[0].z);
        void'(q8.pop_front());
      end
      if (if8.abort && if8.busy) q8.delete();
      else if (if8.in_valid && if8.in_ready && !if8.abort)
        q8.push_back('{ref_mul(W8, if8.is_signed, 32'(if8.a), 32'(if8.b)), cyc + 1});
    end
    ov8_q <= if8.out_valid;
  end

  // Monitor for the WIDTH=16 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      q16.delete();
    end else begin
      if (if16.out_valid && !ov16_q) begin
        if (q16.size() == 0) check("w16_spurious_out_valid", 64'(q16.size()), 64'd1);
        else check("w16_latency", 64'(cyc - q16[0].edge_no), 64'(W16));
      end
      if (if16.out_valid && if16.out_ready && !if16.abort && q16.size() > 0) begin
        check("w16_z", 64'(if16.z), q16[0].z);
        void'(q16.pop_front());
      end
      if (if16.abort && if16.busy) q16.delete();
      else if (if16.in_valid && if16.in_ready && !if16.abort)
        q16.push_back('{ref_mul(W16, if16.is_signed, 32'(if16.a), 32'(if16.b)), cyc + 1});
    end
    ov16_q <= if16.out_valid;
  end

  // Random consumer stalls on the WIDTH=16 instance.
  initial begin
    if16.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if16.out_ready = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic issue8(bit sgn, logic [7:0] a, logic [7:0] b);
    int n = 0;
    if8.in_valid = 1'b1; if8.is_signed = sgn; if8.a = a; if8.b = b;
    while (!if8.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("w8_accept_ready", 64'(if8.in_ready), 64'd1);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.is_signed = 1'($urandom);
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (!(if8.in_ready && !if8.out_valid) && n < 100) begin @(posedge clk); #1; n++; end
    check("w8_back_to_idle", {62'd0, if8.in_ready, if8.out_valid}, 64'd2);
  endtask

  task automatic issue16(bit sgn, logic [15:0] a, logic [15:0] b);
    int n = 0;
    if16.in_valid = 1'b1; if16.is_signed = sgn; if16.a = a; if16.b = b;
    while (!if16.in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) check("w16_accept_timeout", 64'(if16.in_ready), 64'd1);
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    if16.a = 16'($urandom); if16.b = 16'($urandom); if16.is_signed = 1'($urandom);
  endtask

  task automatic wait_idle16();
    int n = 0;
    while (!(if16.in_ready && !if16.out_valid) && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) check("w16_idle_timeout", {62'd0, if16.in_ready, if16.out_valid}, 64'd2);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    if8.in_valid = 1'b0; if8.is_signed = 1'b0; if8.a = '0; if8.b = '0;
    if8.abort = 1'b0; if8.out_ready = 1'b1;
    if16.in_valid = 1'b0; if16.is_signed = 1'b0; if16.a = '0; if16.b = '0;
    if16.abort = 1'b0;

    // Reset values
    #12;
    check("rst_in_ready", 64'(if8.in_ready), 64'd1);
    check("rst_out_valid", 64'(if8.out_valid), 64'd0);
    check("rst_busy", 64'(if8.busy), 64'd0);
    check("rst_z", 64'(if8.z), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0xFF*0xFF unsigned: exact latency, in_ready low throughout
    issue8(1'b0, 8'hFF, 8'hFF);
    for (int i = 0; i < int'(W8); i++) begin
      check("ff_in_ready_low", 64'(if8.in_ready), 64'd0);
      check("ff_no_early_valid", 64'(if8.out_valid), 64'd0);
      @(posedge clk); #1;
    end
    check("ff_valid_at_latency", 64'(if8.out_valid), 64'd1);
    check("ff_z", 64'(if8.z), 64'hFE01);
    check("ff_in_ready_in_done", 64'(if8.in_ready), 64'd0);
    wait_idle8();

    // Signed corner cases
    issue8(1'b1, 8'h80, 8'h80); wait_idle8();
    issue8(1'b1, 8'h80, 8'h7F); wait_idle8();
    issue8(1'b1, 8'hFD, 8'h05); wait_idle8();

    // 12*10 with the consumer stalled for 5 cycles
    if8.out_ready = 1'b0;
    issue8(1'b0, 8'd12, 8'd10);
    for (int n = 0; n < 50 && !if8.out_valid; n++) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 64'(if8.out_valid), 64'd1);
      check("stall_z", 64'(if8.z), 64'd120);
      if8.in_valid = 1'b1; if8.a = 8'd99; if8.b = 8'd99;
      @(posedge clk); #1;
    end
    check("stall_no_accept_in_done", 64'(if8.in_ready), 64'd0);
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_consumed", 64'(if8.out_valid), 64'd0);
    check("stall_in_ready_after", 64'(if8.in_ready), 64'd1);

    // Abort on the third BUSY cycle of 200*200
    issue8(1'b0, 8'd200, 8'd200);
    @(posedge clk); #1;
    @(posedge clk); #1;
    if8.abort = 1'b1;
    @(posedge clk); #1;
    if8.abort = 1'b0;
    check("abort_idle", 64'(if8.in_ready), 64'd1);
    check("abort_busy", 64'(if8.busy), 64'd0);
    repeat (10) begin
      @(posedge clk); #1;
      check("abort_no_valid", 64'(if8.out_valid), 64'd0);
    end
    issue8(1'b0, 8'd3, 8'd4); wait_idle8();

    // Abort together with in_valid in IDLE: no accept
    if8.in_valid = 1'b1; if8.abort = 1'b1; if8.a = 8'd5; if8.b = 8'd5;
    @(posedge clk); #1;
    if8.in_valid = 1'b0; if8.abort = 1'b0;
    check("abort_beats_accept", 64'(if8.busy), 64'd0);

    // Asynchronous reset mid-BUSY of 0x55*0xAA
    issue8(1'b0, 8'h55, 8'hAA);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(if8.in_ready), 64'd1);
    check("arst_out_valid", 64'(if8.out_valid), 64'd0);
    check("arst_z", 64'(if8.z), 64'd0);
    check("arst_busy", 64'(if8.busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue8(1'b0, 8'd7, 8'd9); wait_idle8();

    // Random WIDTH=16 sweep with consumer stalls
    rand_stall = 1'b1;
    for (int k = 0; k < int'(N_RAND); k++) begin
      issue16(1'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) wait_idle16();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_idle16();
    rand_stall = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("w8_queue_drained", 64'(q8.size()), 64'd0);
    check("w16_queue_drained", 64'(q16.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
